bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning BRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning BRAM address width (depth 2^ADDR_WIDTH).
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request one burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first word address, captured with start.
REQ-007 SHALL have port length  input  ADDR_WIDTH+1  word count, captured with start; 0 allowed.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port readEnable  output  1  BRAM read strobe.
REQ-011 SHALL have port readAddress  output  ADDR_WIDTH  BRAM read address.
REQ-012 SHALL have port readData  input  DATA_WIDTH  BRAM data, valid exactly one cycle after the readEnable cycle.
REQ-013 SHALL have port out_valid  output  1  out_data holds a word.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-015 SHALL have port out_data  output  DATA_WIDTH  streamed word.
REQ-016 SHALL have port out_last  output  1  marks the final word of a burst.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-018 IDLE->READ SHALL occur on a clock edge with start=1 and length!=0; IDLE->DONE SHALL occur on start=1 with length=0.
REQ-019 In READ, readEnable SHALL be asserted combinationally when issued<length and (in_flight + fifo_count) < 2.
REQ-020 readAddress SHALL equal (base_addr + issued) mod 2^ADDR_WIDTH, wrapping past the top address without error.
REQ-021 The word returned one cycle after each readEnable SHALL be written into a 2-entry FIFO; no word SHALL ever be dropped or duplicated.
REQ-022 out_valid SHALL equal FIFO non-empty, and out_data SHALL be the FIFO head.
REQ-023 A beat SHALL transfer on out_valid & out_ready; once asserted, out_valid/out_data SHALL hold until the transfer completes.
REQ-024 A simultaneous FIFO push and pop SHALL leave the occupancy unchanged.
REQ-025 READ->DRAIN SHALL occur when issued reaches length; DRAIN->DONE SHALL occur on the handshake of the final beat.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 Latency SHALL be: start edge at N -> first readEnable in cycle N+1 -> out_valid in cycle N+2.
REQ-028 With out_ready held high, throughput SHALL be one word per cycle.
REQ-029 start SHALL be ignored while busy=1.

Reset
REQ-030 reset SHALL asynchronously force state IDLE, FIFO empty, in_flight=0, and issued=0.
REQ-031 Under reset, busy, done, readEnable, out_valid, and out_last SHALL be 0, and readAddress and out_data SHALL be 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst; a read returning after reset SHALL be discarded.

Configuration
REQ-033 With macro BRAM_READER_LAST_EN defined, out_last SHALL be 1 exactly while the head word is the burst's final word.
REQ-034 Without BRAM_READER_LAST_EN, out_last SHALL be tied to 0 and no last-tracking logic SHALL be built.

Verification
REQ-035 base_addr=0x10, length=4, out_ready=1 -> words from 0x10..0x13 on 4 consecutive cycles starting at start+2; out_last on the 4th word; done one cycle after.
REQ-036 base_addr=0xFE, length=4 -> addresses issued in order 0xFE, 0xFF, 0x00, 0x01; data order preserved.
REQ-037 length=8, out_ready toggled 1/0 each cycle -> all 8 words delivered in order; no readEnable while in_flight+fifo_count=2.
REQ-038 length=0 -> no readEnable and no out_valid; done pulses one cycle after start.
REQ-039 reset pulsed at the 3rd beat of length=6 -> all outputs 0 immediately; a following start with length=2 streams exactly 2 correct words.
REQ-040 start pulsed while busy -> ignored; the current burst completes unchanged.

Source files
------------

// File: rtl/bram_stream_reader_if.sv
// Control, BRAM read port and output stream signals of bram_stream_reader.
// The reader connects through the slave modport; its environment uses master.
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;
    logic                  readEnable;
    logic [ADDR_WIDTH-1:0] readAddress;
    logic [DATA_WIDTH-1:0] readData;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport slave (
        input  start, base_addr, length, readData, out_ready,
        output busy, done, readEnable, readAddress, out_valid, out_data, out_last
    );

    modport master (
        output start, base_addr, length, readData, out_ready,
        input  busy, done, readEnable, readAddress, out_valid, out_data, out_last
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams a burst of BRAM words through a 2-entry first-word-fall-through FIFO.
// Define BRAM_READER_LAST_EN to build out_last tracking; otherwise out_last is 0.
module bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    bram_stream_reader_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] baseReg;
    logic [ADDR_WIDTH:0]   lenReg;
    logic [ADDR_WIDTH:0]   issued;
    logic                  inFlight;

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wrPtr;
    logic                  rdPtr;
    logic [1:0]            count;

    logic issue;
    logic headStored;
    logic pop;
    logic popStored;
    logic push;
    logic lastBeat;
    logic lastIssue;

    // The word on readData is presented directly when nothing is stored, so a
    // returning word is visible in the same cycle it arrives and is only
    // written into storage if it cannot leave immediately.
    always_comb begin
        headStored = count != 2'd0;
        issue      = (state == READ) && (issued < lenReg)
                     && (({1'b0, inFlight} + count) < 2'd2);
        lastIssue  = issue && ((issued + ONE) == lenReg);
        pop        = (headStored | inFlight) & bus.out_ready;
        popStored  = pop & headStored;
        push       = inFlight & ~(pop & ~headStored);
        lastBeat   = pop && (({1'b0, inFlight} + count) == 2'd1);
    end

    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.readEnable  = issue;
    assign bus.readAddress = baseReg + issued[ADDR_WIDTH-1:0];
    assign bus.out_valid   = headStored | inFlight;
    assign bus.out_data    = headStored ? mem[rdPtr] : (inFlight ? bus.readData : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baseReg  <= '0;
            lenReg   <= '0;
            issued   <= '0;
            inFlight <= 1'b0;
        end else begin
            inFlight <= issue;
            if (issue) issued <= issued + ONE;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        baseReg <= bus.base_addr;
                        lenReg  <= bus.length;
                        issued  <= '0;
                        state   <= (bus.length == '0) ? DONE : READ;
                    end
                end
                READ:    if (lastIssue) state <= DRAIN;
                DRAIN:   if (lastBeat) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= '0;
        end else begin
            if (push) wrPtr <= ~wrPtr;
            if (popStored) rdPtr <= ~rdPtr;
            case ({push, popStored})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wrPtr] <= bus.readData;
    end

`ifdef BRAM_READER_LAST_EN
    logic inFlightLast;
    logic memLast [2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) inFlightLast <= 1'b0;
        else       inFlightLast <= lastIssue;
    end

    always_ff @(posedge clock) begin
        if (push) memLast[wrPtr] <= inFlightLast;
    end

    assign bus.out_last = headStored ? memLast[rdPtr] : (inFlight & inFlightLast);
`else
    assign bus.out_last = 1'b0;
`endif
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed and randomized bursts against a BRAM array model; expected words,
// addresses and timing are derived from the burst parameters.
module tb_bram_stream_reader;
    localparam int DW = 32;
    localparam int AW = 8;
`ifdef BRAM_READER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] bramMem [1 << AW];

    // Synchronous-read BRAM; garbage on readData whenever no read was issued.
    always @(posedge clock)
        bus.readData <= bus.readEnable ? bramMem[bus.readAddress] : DW'($urandom);

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [AW-1:0] curBase;
    int            curLen;
    int            issuedCnt, acceptedCnt, k;
    int            firstReK, firstValidK, lastBeatK, doneK, doneCount;
    logic          heldValid;
    logic [DW-1:0] heldData;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] expWord(input int i);
        logic [AW-1:0] a;
        a = curBase + AW'(i);
        return bramMem[a];
    endfunction

    task automatic step();
        logic [AW-1:0] expAddr;
        @(negedge clock);
        if (bus.readEnable) begin
            expAddr = curBase + AW'(issuedCnt);
            check("rdAddr", bus.readAddress, expAddr);
            check("rdOutstanding", (issuedCnt - acceptedCnt) < 2, 1);
            check("rdCount", issuedCnt < curLen, 1);
            if (firstReK < 0) firstReK = k;
            issuedCnt++;
        end
        if (heldValid) begin
            check("holdValid", bus.out_valid, 1);
            check("holdData", bus.out_data, heldData);
        end
        if (bus.out_valid && firstValidK < 0) firstValidK = k;
        if (bus.out_valid && bus.out_ready) begin
            check("beatData", bus.out_data, expWord(acceptedCnt));
            check("beatLast", bus.out_last, LAST_EN && (acceptedCnt == curLen - 1));
            lastBeatK = k;
            acceptedCnt++;
        end
        heldValid = bus.out_valid && !bus.out_ready;
        heldData  = bus.out_data;
        if (bus.done) begin
            doneCount++;
            doneK = k;
        end
        @(posedge clock);
        #1;
        k++;
    endtask

    // mode: 0 ready always high, 1 ready toggles, 2 ready random.
    task automatic runBurst(input logic [AW-1:0] base, input int len, input int mode,
                            input int pokeK, input int abortAt);
        int budget;
        budget = len * 8 + 40;
        curBase = base; curLen = len;
        issuedCnt = 0; acceptedCnt = 0; k = 0;
        firstReK = -1; firstValidK = -1; lastBeatK = -1; doneK = -1; doneCount = 0;
        heldValid = 1'b0;
        bus.base_addr = base;
        bus.length    = (AW+1)'(len);
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        check("idleBusy", bus.busy, 0);
        step();
        while (doneK < 0 && k < budget) begin
            if (abortAt >= 0 && acceptedCnt == abortAt) return;
            bus.start     = (k == pokeK);
            bus.base_addr = AW'($urandom);
            bus.length    = (AW+1)'($urandom_range(0, 20));
            bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? k[0] : 1'($urandom);
            step();
        end
        bus.start = 1'b0;
        check("doneSeen", doneK >= 0, 1);
        check("wordsOut", acceptedCnt, len);
        check("readsIssued", issuedCnt, len);
        check("busyAfterDone", bus.busy, 0);
        step();
        check("doneOnce", doneCount, 1);
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, "Busy"}, bus.busy, 0);
        check({tag, "Done"}, bus.done, 0);
        check({tag, "ReadEnable"}, bus.readEnable, 0);
        check({tag, "ReadAddress"}, bus.readAddress, 0);
        check({tag, "OutValid"}, bus.out_valid, 0);
        check({tag, "OutData"}, bus.out_data, 0);
        check({tag, "OutLast"}, bus.out_last, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) bramMem[i] = $urandom;
        reset = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
        #1;
        checkZeroOutputs("rst");
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        // Nominal burst: latency and back-to-back throughput.
        runBurst(8'h10, 4, 0, -1, -1);
        check("firstReadCycle", firstReK, 1);
        check("firstValidCycle", firstValidK, 2);
        check("lastBeatCycle", lastBeatK, 5);
        check("doneCycle", doneK, 6);

        // Address wrap past the top of the BRAM.
        runBurst(8'hFE, 4, 0, -1, -1);
        check("wrapDoneCycle", doneK, 6);

        // Zero-length burst.
        runBurst(8'h20, 0, 0, -1, -1);
        check("zeroNoRead", firstReK, -1);
        check("zeroNoValid", firstValidK, -1);
        check("zeroDoneCycle", doneK, 1);

        // Backpressure with out_ready toggling.
        runBurst(8'h40, 8, 1, -1, -1);

        // start pulsed mid-burst is ignored.
        runBurst(8'h80, 6, 0, 3, -1);
        check("pokeDoneCycle", doneK, 8);

        // Reset at the third beat aborts the burst.
        runBurst(8'h30, 6, 0, -1, 2);
        #2 reset = 1'b1;
        #1;
        checkZeroOutputs("midRst");
        @(posedge clock); #1;
        check("rstDiscardValid", bus.out_valid, 0);
        reset = 1'b0;
        curLen = 0; issuedCnt = 0; acceptedCnt = 0; heldValid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rstNoStaleBeat", acceptedCnt, 0);
        runBurst(8'h50, 2, 0, -1, -1);
        check("postRstDoneCycle", doneK, 4);

        // Randomized bursts with random backpressure.
        for (int b = 0; b < 8; b++)
            runBurst(AW'($urandom), $urandom_range(1, 12), 2, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
